// File: rtl/seg_runner_ctrl_if.sv
// rtl/seg_runner_ctrl_if.sv - control/status bundle between the runner controller and its driver
//
// Signals:
//   run     driver -> ctrl  level, 1 = runner moving
//   stop    driver -> ctrl  single-cycle stop pulse
//   pos     ctrl -> driver  one-hot runner position, bit 7 leftmost
//   step    ctrl -> driver  pulse on each position change
//   hit     ctrl -> driver  pulse when a stop is captured
//   hit_pos ctrl -> driver  index of pos at the last capture
// Modports: master (game logic / bench side), slave (seg_runner_ctrl side).

interface seg_runner_ctrl_if;
  logic       run;
  logic       stop;
  logic [7:0] pos;
  logic       step;
  logic       hit;
  logic [2:0] hit_pos;

  modport master (
    output run,
    output stop,
    input  pos,
    input  step,
    input  hit,
    input  hit_pos
  );

  modport slave (
    input  run,
    input  stop,
    output pos,
    output step,
    output hit,
    output hit_pos
  );
endinterface

// File: rtl/seg_runner_ctrl.sv
// rtl/seg_runner_ctrl.sv - one-hot position generator for the seven-segment runner game
//
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   bus  seg_runner_ctrl_if.slave: run/stop in, pos/step/hit/hit_pos out (all registered)
// Parameters:
//   CLK_DIV  clocks per position step (>= 1)
// Build option:
//   SEG_RUNNER_BOUNCE_EN  defined: ping-pong motion between bit 7 and bit 0;
//                         undefined: always moves right, wrapping bit 0 -> bit 7.

module seg_runner_ctrl #(
  parameter int CLK_DIV = 25000000
) (
  input logic              clk,
  input logic              rst,
  seg_runner_ctrl_if.slave bus
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       pos_q;
  logic [7:0]       pos_d;
  logic             step_q;
  logic             hit_q;
  logic [2:0]       hit_pos_q;
  logic [2:0]       pos_idx;

`ifdef SEG_RUNNER_BOUNCE_EN
  logic dir_left_q;
  logic dir_left_d;
`endif

  // Binary index of the one-hot position.
  always_comb begin
    pos_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (pos_q[i]) pos_idx = i[2:0];
    end
  end

  // Position after one advance.
`ifdef SEG_RUNNER_BOUNCE_EN
  always_comb begin
    pos_d      = pos_q;
    dir_left_d = dir_left_q;
    if (dir_left_q) begin
      if (pos_q[7]) begin
        pos_d      = 8'h40;
        dir_left_d = 1'b0;
      end else begin
        pos_d = pos_q << 1;
      end
    end else begin
      if (pos_q[0]) begin
        pos_d      = 8'h02;
        dir_left_d = 1'b1;
      end else begin
        pos_d = pos_q >> 1;
      end
    end
  end
`else
  always_comb begin
    pos_d = {pos_q[0], pos_q[7:1]};
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pos_q      <= 8'h80;
      step_q     <= 1'b0;
      hit_q      <= 1'b0;
      hit_pos_q  <= 3'd0;
`ifdef SEG_RUNNER_BOUNCE_EN
      dir_left_q <= 1'b0;
`endif
    end else begin
      step_q <= 1'b0;
      hit_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (bus.run) state_q <= RUN;
        end
        RUN: begin
          // Priority: run low, then stop, then terminal count.
          if (!bus.run) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (bus.stop) begin
            state_q   <= HOLD;
            cnt_q     <= '0;
            hit_q     <= 1'b1;
            hit_pos_q <= pos_idx;
          end else if (cnt_q == CNT_LAST) begin
            cnt_q      <= '0;
            pos_q      <= pos_d;
            step_q     <= 1'b1;
`ifdef SEG_RUNNER_BOUNCE_EN
            dir_left_q <= dir_left_d;
`endif
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        HOLD: begin
          cnt_q <= '0;
          if (!bus.run) state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.pos     = pos_q;
  assign bus.step    = step_q;
  assign bus.hit     = hit_q;
  assign bus.hit_pos = hit_pos_q;

endmodule

// File: tb/tb_seg_runner_ctrl.sv
// tb/tb_seg_runner_ctrl.sv - randomized self-checking bench for seg_runner_ctrl

module tb_seg_runner_ctrl;

  localparam int DIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  seg_runner_ctrl_if bus ();

  seg_runner_ctrl #(.CLK_DIV(DIV)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: runner position as an index 7..0, plus activity flags.
  int m_idx;
  bit m_left;
  bit m_moving;
  bit m_frozen;
  int m_elapsed;
  bit e_step;
  bit e_hit;
  int e_hit_pos;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_idx     = 7;
    m_left    = 1'b0;
    m_moving  = 1'b0;
    m_frozen  = 1'b0;
    m_elapsed = 0;
    e_step    = 1'b0;
    e_hit     = 1'b0;
    e_hit_pos = 0;
  endtask

  task automatic model_advance();
`ifdef SEG_RUNNER_BOUNCE_EN
    if (m_left) begin
      if (m_idx == 7) begin
        m_idx  = 6;
        m_left = 1'b0;
      end else m_idx = m_idx + 1;
    end else begin
      if (m_idx == 0) begin
        m_idx  = 1;
        m_left = 1'b1;
      end else m_idx = m_idx - 1;
    end
`else
    m_idx = (m_idx + 7) % 8;
`endif
  endtask

  task automatic model_edge(input bit r, input bit s);
    e_step = 1'b0;
    e_hit  = 1'b0;
    if (!m_moving && !m_frozen) begin
      if (r) begin
        m_moving  = 1'b1;
        m_elapsed = 0;
      end
    end else if (!r) begin
      m_moving = 1'b0;
      m_frozen = 1'b0;
    end else if (m_frozen) begin
      // held until run drops
    end else if (s) begin
      m_moving  = 1'b0;
      m_frozen  = 1'b1;
      e_hit     = 1'b1;
      e_hit_pos = m_idx;
    end else begin
      m_elapsed++;
      if (m_elapsed == DIV) begin
        m_elapsed = 0;
        model_advance();
        e_step = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    check("pos", 32'(bus.pos), 32'(1) << m_idx);
    check("step", 32'(bus.step), 32'(e_step));
    check("hit", 32'(bus.hit), 32'(e_hit));
    check("hit_pos", 32'(bus.hit_pos), 32'(e_hit_pos));
  endtask

  // One clock: drive inputs, let the edge happen, compare on the falling edge.
  task automatic tick(input bit r, input bit s);
    bus.run  = r;
    bus.stop = s;
    @(posedge clk);
    model_edge(r, s);
    @(negedge clk);
    bus.stop = 1'b0;
    check_all();
  endtask

  // Keep running until the model reaches index idx (and elapsed el if el >= 0).
  task automatic run_until(input int idx, input int el);
    int n;
    if (m_frozen) tick(1'b0, 1'b0);
    n = 0;
    while (!(m_moving && m_idx == idx && (el < 0 || m_elapsed == el)) && n < 200) begin
      tick(1'b1, 1'b0);
      n++;
    end
    if (n >= 200) check("run_until_timeout", 32'(n), 32'(0));
  endtask

  // Reset asserted between edges; outputs must clear without a clock.
  task automatic async_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_pos", 32'(bus.pos), 32'h80);
    check("rst_step", 32'(bus.step), 32'd0);
    check("rst_hit", 32'(bus.hit), 32'd0);
    check("rst_hit_pos", 32'(bus.hit_pos), 32'd0);
    model_reset();
    bus.run  = 1'b0;
    bus.stop = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bus.run  = 1'b0;
    bus.stop = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst = 1'b0;
    @(negedge clk);
    check_all();

    // Start and full traversal.
    repeat (48) tick(1'b1, 1'b0);

    // Stop capture at 0x10, then stay frozen with run high.
    run_until(4, -1);
    tick(1'b1, 1'b1);
    check("capture_hit_pos", 32'(bus.hit_pos), 32'd4);
    repeat (20) tick(1'b1, 1'b0);
    check("hold_pos", 32'(bus.pos), 32'h10);

    // Stop on the terminal-count cycle at 0x08.
    run_until(3, DIV - 1);
    tick(1'b1, 1'b1);
    check("collide_pos", 32'(bus.pos), 32'h08);
    tick(1'b0, 1'b0);

    // Run dropped together with stop on the terminal-count cycle.
    run_until(3, DIV - 1);
    tick(1'b0, 1'b1);
    check("drop_no_hit", 32'(bus.hit), 32'd0);

    // Pause at 0x04 and resume.
    run_until(2, 0);
    repeat (10) tick(1'b0, 1'b0);
    check("pause_pos", 32'(bus.pos), 32'h04);
    repeat (DIV) tick(1'b1, 1'b0);

    // Asynchronous reset mid-RUN at 0x02.
    run_until(1, -1);
    async_reset();
    check_all();

    // Randomized phase.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) async_reset();
      else tick($urandom_range(0, 24) != 0, $urandom_range(0, 19) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
